// File: rtl/cla_seq_pkg.sv
// Shared definitions for the nibble-serial add/subtract sequencer:
// FSM state encoding and helpers that size the nibble index counter.
package cla_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int NIB_BITS = 4;

  // Number of nibble passes needed for a given operand width.
  function automatic int nib_count(input int width);
    return width / NIB_BITS;
  endfunction

  // Index counter width: clog2 of the nibble count, never below one bit.
  function automatic int idx_width(input int width);
    int n;
    n = width / NIB_BITS;
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cla4_slice.sv
// Purely combinational 4-bit carry-lookahead adder slice.
module cla4_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  // Per-bit generate/propagate terms and sum bits.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_bit
      assign g[gi] = a[gi] & b[gi];
      assign p[gi] = a[gi] ^ b[gi];
      assign s[gi] = p[gi] ^ c[gi];
    end
  endgenerate

  // Flattened lookahead: every carry is computed from cin and g/p directly,
  // so no carry ripples through another carry.
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);

  assign cout = c[4];

endmodule

// File: rtl/cla_nibble_seq_ctrl.sv
// WIDTH-bit add/subtract built from one 4-bit lookahead slice reused over
// WIDTH/4 cycles, least-significant nibble first, with valid/ready handshakes
// on the operand and result sides.
module cla_nibble_seq_ctrl
  import cla_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             op_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NIB  = nib_count(WIDTH);
  localparam int IDXW = idx_width(WIDTH);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIB - 1);

  state_t            state_q, state_d, state_dec;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]  a_sh_q, a_sh_d;
  logic [WIDTH-1:0]  b_sh_q, b_sh_d;
  logic [WIDTH-1:0]  acc_q, acc_d;
  logic              carry_q, carry_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              cout_q, cout_d;
  logic              ovf_q, ovf_d;
  logic              out_valid_q, out_valid_d;

  logic [3:0]        slice_s;
  logic              slice_cout;
  logic [WIDTH-1:0]  acc_shifted;

  cla4_slice u_slice (
    .a    (a_sh_q[3:0]),
    .b    (b_sh_q[3:0]),
    .cin  (carry_q),
    .s    (slice_s),
    .cout (slice_cout)
  );

  // New nibble enters at the top of the accumulator as older nibbles move down.
  assign acc_shifted = (acc_q >> 4) | (WIDTH'(slice_s) << (WIDTH - 4));

  // Decode the state register; the unused encoding behaves as IDLE.
  always_comb begin
    state_dec = ST_IDLE;
    case (state_q)
      ST_RUN:  state_dec = ST_RUN;
      ST_DONE: state_dec = ST_DONE;
      default: state_dec = ST_IDLE;
    endcase
  end

  assign in_ready  = (state_dec == ST_IDLE);
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

  // Next-state, datapath shifting and result capture.
  always_comb begin
    state_d     = state_dec;
    idx_d       = idx_q;
    a_sh_d      = a_sh_q;
    b_sh_d      = b_sh_q;
    acc_d       = acc_q;
    carry_d     = carry_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;

    case (state_dec)
      ST_IDLE: begin
        if (in_valid) begin
          // Subtraction is a + ~b + ~cin, so invert b and the carry-in here.
          state_d = ST_RUN;
          a_sh_d  = a;
          b_sh_d  = op_sub ? ~b : b;
          carry_d = cin ^ op_sub;
          idx_d   = '0;
        end
      end
      ST_RUN: begin
        a_sh_d  = a_sh_q >> 4;
        b_sh_d  = b_sh_q >> 4;
        carry_d = slice_cout;
        acc_d   = acc_shifted;
        idx_d   = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          // Top nibble: the operand MSBs are still at bit 3 of the shifters.
          state_d     = ST_DONE;
          idx_d       = '0;
          sum_d       = acc_shifted;
          cout_d      = slice_cout;
          ovf_d       = (a_sh_q[3] ~^ b_sh_q[3]) & (a_sh_q[3] ^ slice_s[3]);
          out_valid_d = 1'b1;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      acc_q       <= '0;
      carry_q     <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      a_sh_q      <= a_sh_d;
      b_sh_q      <= b_sh_d;
      acc_q       <= acc_d;
      carry_q     <= carry_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_cla_nibble_seq_ctrl.sv
// Self-checking bench: a 16-bit and a 4-bit instance checked against an
// integer-arithmetic reference model.
module tb_cla_nibble_seq_ctrl;

  typedef struct {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // 16-bit instance
  logic        in_valid = 1'b0, in_ready, op_sub = 1'b0, cin_i = 1'b0;
  logic [15:0] a_i = '0, b_i = '0, sum_o;
  logic        out_valid, out_ready = 1'b0, cout_o, ovf_o;

  // 4-bit instance, result side always ready
  logic        in_valid4 = 1'b0, in_ready4, op_sub4 = 1'b0, cin4 = 1'b0;
  logic [3:0]  a4 = '0, b4 = '0, sum4;
  logic        out_valid4, cout4, ovf4;

  int n_vec = 0;
  int n_err = 0;

  cla_nibble_seq_ctrl #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a_i), .b(b_i), .cin(cin_i), .op_sub(op_sub), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum_o), .cout(cout_o), .ovf(ovf_o)
  );

  cla_nibble_seq_ctrl #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a4), .b(b4), .cin(cin4), .op_sub(op_sub4), .out_valid(out_valid4),
    .out_ready(1'b1), .sum(sum4), .cout(cout4), .ovf(ovf4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic, unsigned for sum/cout, signed for ovf.
  function automatic res_t model(input int width, input logic [15:0] a, input logic [15:0] b,
                                 input logic c, input logic s);
    res_t   r;
    longint m, ua, ub, sa, sb, ru, rs;
    m  = longint'(1) << width;
    ua = longint'(a) & (m - 1);
    ub = longint'(b) & (m - 1);
    sa = (ua >= m / 2) ? ua - m : ua;
    sb = (ub >= m / 2) ? ub - m : ub;
    ru = s ? (ua - ub - longint'(c)) : (ua + ub + longint'(c));
    rs = s ? (sa - sb - longint'(c)) : (sa + sb + longint'(c));
    r.sum  = 16'((ru + 2 * m) % m);
    r.cout = s ? (ru >= 0) : (ru >= m);
    r.ovf  = (rs < -(m / 2)) || (rs >= m / 2);
    return r;
  endfunction

  // One 16-bit transaction with 'hold' cycles of result backpressure.
  task automatic run16(input string tag, input logic [15:0] ia, input logic [15:0] ib,
                       input logic ic, input logic is, input int hold);
    res_t e;
    int   lat;
    e = model(16, ia, ib, ic, is);
    @(negedge clk);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    a_i = ia; b_i = ib; cin_i = ic; op_sub = is; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'd4);
    check({tag, "_sum"}, 32'(sum_o), 32'(e.sum));
    check({tag, "_cout_ovf"}, {30'd0, cout_o, ovf_o}, {30'd0, e.cout, e.ovf});
    repeat (hold) begin
      in_valid = 1'b1; a_i = 16'($urandom); b_i = 16'($urandom);
      @(negedge clk);
      check({tag, "_hold"}, {13'd0, out_valid, in_ready, cout_o, sum_o},
            {13'd0, 1'b1, 1'b0, e.cout, e.sum});
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_release"}, {14'd0, out_valid, in_ready, sum_o}, {14'd0, 1'b0, 1'b1, e.sum});
    $display("op %s: a=%h b=%h cin=%0b sub=%0b -> sum=%h cout=%0b ovf=%0b lat=%0d",
             tag, ia, ib, ic, is, sum_o, cout_o, ovf_o, lat);
  endtask

  initial begin
    res_t        e;
    res_t        exp_q[$];
    int          lat, cyc, last_cyc;

    // Reset state of both instances
    #2;
    check("rst_out16", {13'd0, in_ready, out_valid, cout_o, ovf_o, sum_o}, {13'd0, 4'b1000, 16'h0});
    check("rst_out4", {24'd0, in_ready4, out_valid4, cout4, ovf4, sum4}, {24'd0, 4'b1000, 4'h0});
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases
    run16("add_basic", 16'h1234, 16'h4321, 1'b0, 1'b0, 0);
    run16("add_carry_chain", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1);
    run16("sub_borrow", 16'h0005, 16'h0007, 1'b0, 1'b1, 0);
    run16("sub_ovf", 16'h8000, 16'h0001, 1'b0, 1'b1, 2);
    run16("add_ovf_bp", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 10);

    // Reset on the second RUN cycle: outputs drop at once, no result appears
    @(negedge clk);
    a_i = 16'h1111; b_i = 16'h2222; cin_i = 1'b0; op_sub = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrun_rst", {13'd0, in_ready, out_valid, cout_o, ovf_o, sum_o}, {13'd0, 4'b1000, 16'h0});
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("midrun_no_result", 32'(out_valid), 32'd0);
    $display("op reset_abort: a=1111 b=2222 aborted on 2nd RUN cycle");
    run16("after_rst", 16'h00FF, 16'h0F01, 1'b0, 1'b0, 0);

    // Randomized 16-bit operations
    for (int i = 0; i < 25; i++) begin
      run16($sformatf("rnd%0d", i), 16'($urandom), 16'($urandom),
            1'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
    end

    // 4-bit instance: single op, one-edge latency
    @(negedge clk);
    a4 = 4'hF; b4 = 4'h1; cin4 = 1'b1; op_sub4 = 1'b0; in_valid4 = 1'b1;
    @(negedge clk);
    in_valid4 = 1'b0;
    lat = 0;
    while (!out_valid4 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("w4_latency", 32'(lat), 32'd1);
    check("w4_result", {27'd0, cout4, sum4}, {27'd0, 1'b1, 4'h1});
    $display("op w4_single: a=f b=1 cin=1 -> sum=%h cout=%0b lat=%0d", sum4, cout4, lat);
    @(negedge clk);

    // 4-bit instance: continuous offers; each result is IDLE + one RUN + DONE apart
    cyc = 0;
    last_cyc = -1;
    for (int i = 0; i < 34; i++) begin
      cyc++;
      if (out_valid4) begin
        if (exp_q.size() == 0) begin
          check("w4_b2b_unexpected", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("w4_b2b_result", {26'd0, ovf4, cout4, sum4}, {26'd0, e.ovf, e.cout, e.sum[3:0]});
          $display("op w4_b2b: sum=%h cout=%0b ovf=%0b at cycle %0d", sum4, cout4, ovf4, cyc);
        end
        if (last_cyc >= 0) check("w4_b2b_interval", 32'(cyc - last_cyc), 32'd3);
        last_cyc = cyc;
      end
      if (i < 28) begin
        a4 = 4'($urandom); b4 = 4'($urandom); cin4 = 1'($urandom); op_sub4 = 1'($urandom);
        in_valid4 = 1'b1;
        if (in_ready4) exp_q.push_back(model(4, {12'd0, a4}, {12'd0, b4}, cin4, op_sub4));
      end else begin
        in_valid4 = 1'b0;
      end
      @(negedge clk);
    end
    check("w4_b2b_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
